// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring trial-subtract for divide.
// The divide path exists only when MULDIV_SEQ_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
`ifdef MULDIV_SEQ_DIV_EN
  input  logic               i_div,
`endif
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mulAcc;
`ifdef MULDIV_SEQ_DIV_EN
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_divAcc;
`endif

  // Multiply: acc = {partial, multiplier}; add on LSB then shift right with the carry.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_mulAcc = {w_sum, i_acc[WIDTH-1:1]};
`ifdef MULDIV_SEQ_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}; shift left, keep the trial if it fits.
    w_shift  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_diff   = w_shift - {1'b0, i_operand};
    w_ge     = (w_shift >= {1'b0, i_operand});
    w_divAcc = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
    o_acc    = i_div ? w_divAcc : w_mulAcc;
`else
    o_acc    = w_mulAcc;
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 34-cycle start-to-done latency.
// Define MULDIV_SEQ_DIV_EN to build the restoring divider; otherwise divides complete at once with dz=1.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_nextState;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_stepAcc;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     r_operand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic [WIDTH-1:0]     w_resHi;
  logic [WIDTH-1:0]     w_resLo;
  logic                 w_resDz;
  logic                 r_negRes;
  logic                 r_done;
  logic                 r_dz;
  logic                 w_accept;
  logic                 w_runStart;
  logic                 w_aNeg;
  logic                 w_bNeg;
`ifdef MULDIV_SEQ_DIV_EN
  logic                 r_isDiv;
  logic                 r_negRem;
  logic                 r_bZero;
  logic [WIDTH-1:0]     r_aOrig;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
`ifdef MULDIV_SEQ_DIV_EN
    .i_div     (r_isDiv),
`endif
    .o_acc     (w_stepAcc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_accept = start && (r_state == S_IDLE);
`ifdef MULDIV_SEQ_DIV_EN
    w_runStart = w_accept;
`else
    w_runStart = w_accept && !op[1];
`endif
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_runStart) w_nextState = S_RUN;
      S_RUN:   if (r_count == CW'(WIDTH-1)) w_nextState = S_FIX;
      S_FIX:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = r_done;
    dz   = r_dz;
    hi   = r_hi;
    lo   = r_lo;
  end

  // Magnitudes at accept (op[0]=0 means signed) and sign-fixed results for FIX.
  always_comb begin
    w_aNeg  = !op[0] && a[WIDTH-1];
    w_bNeg  = !op[0] && b[WIDTH-1];
    w_absA  = w_aNeg ? -a : a;
    w_absB  = w_bNeg ? -b : b;
    w_prod  = r_negRes ? -r_acc : r_acc;
    w_resHi = w_prod[2*WIDTH-1:WIDTH];
    w_resLo = w_prod[WIDTH-1:0];
    w_resDz = 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
    if (r_isDiv) begin
      if (r_bZero) begin
        w_resLo = '1;
        w_resHi = r_aOrig;
        w_resDz = 1'b1;
      end else begin
        w_resLo = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_resHi = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_negRes  <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
      r_isDiv   <= 1'b0;
      r_negRem  <= 1'b0;
      r_bZero   <= 1'b0;
      r_aOrig   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dz     <= 1'b0;
            r_count  <= '0;
            r_negRes <= w_aNeg ^ w_bNeg;
            if (op[1]) begin
              r_acc     <= {{WIDTH{1'b0}}, w_absA};
              r_operand <= w_absB;
            end else begin
              r_acc     <= {{WIDTH{1'b0}}, w_absB};
              r_operand <= w_absA;
            end
`ifdef MULDIV_SEQ_DIV_EN
            r_isDiv  <= op[1];
            r_negRem <= w_aNeg;
            r_bZero  <= (b == '0);
            r_aOrig  <= a;
`else
            if (op[1]) begin
              r_done <= 1'b1;
              r_dz   <= 1'b1;
            end
`endif
          end else begin
            // A start in the same cycle takes priority and drops the MT write.
            if (mthi) r_hi <= hi_wdata;
            if (mtlo) r_lo <= lo_wdata;
          end
        end
        S_RUN: begin
          r_acc   <= w_stepAcc;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          r_hi   <= w_resHi;
          r_lo   <= w_resLo;
          r_dz   <= w_resDz;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq; expectations follow MULDIV_SEQ_DIV_EN when defined.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi_wdata = '0;
  logic [31:0] lo_wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

`ifdef MULDIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nChecks = 0;
  int          nPass = 0;
  int          nFail = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic        mDz = 1'b0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of HI/LO/dz after an operation completes.
  task automatic predict(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    if (!o[1]) begin
      if (o[0]) p = {32'b0, x} * {32'b0, y};
      else      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      {mHi, mLo} = p;
      mDz = 1'b0;
    end else if (!DIV_EN) begin
      mDz = 1'b1;
    end else if (y == 32'd0) begin
      mLo = 32'hFFFF_FFFF; mHi = x; mDz = 1'b1;
    end else if (o[0]) begin
      mLo = x / y; mHi = x % y; mDz = 1'b0;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      mLo = 32'h8000_0000; mHi = 32'd0; mDz = 1'b0;
    end else begin
      mLo = 32'($signed(x) / $signed(y));
      mHi = 32'($signed(x) % $signed(y));
      mDz = 1'b0;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input bit useConst, input logic [31:0] cHi,
                               input logic [31:0] cLo, input logic cDz, input bit disturb,
                               input bit withMt);
    exp_t e;
    exp_t got;
    int cyc;
    int busyCnt;
    logic [31:0] prevHi;
    prevHi = mHi;
    predict(o, x, y);
    if (useConst && (!o[1] || DIV_EN)) begin
      mHi = cHi; mLo = cLo; mDz = cDz;
    end
    e.hi = mHi; e.lo = mLo; e.dz = mDz;
    e.lat = (o[1] && !DIV_EN) ? 1 : 34;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    if (withMt) begin mthi = 1'b1; hi_wdata = 32'hDEAD_BEEF; end
    cyc = 0;
    busyCnt = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (withMt && cyc == 1) checkOutput({tag, "_mt_dropped"}, hi, prevHi);
      if (done) break;
      if (busy) busyCnt++;
      if (disturb && (cyc == 5 || cyc == 33)) begin
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
        mthi = 1'b1; hi_wdata = 32'hAA; mtlo = 1'b1; lo_wdata = 32'h55;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_latency"}, cyc, e.lat);
    checkOutput({tag, "_busy_cycles"}, busyCnt, e.lat - 1);
    checkOutput({tag, "_busy_at_done"}, busy, 0);
    if (sb.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      checkOutput({tag, "_hi"}, hi, got.hi);
      checkOutput({tag, "_lo"}, lo, got.lo);
      checkOutput({tag, "_dz"}, dz, got.dz);
    end
  endtask

  initial begin
    int doneCount;
    logic [1:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(negedge clk);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_dz", dz, 0);
    reset = 1'b0;

    applyStimulus("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h1, 0, 0, 0);
    applyStimulus("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0);
    @(negedge clk);
    checkOutput("done_single_pulse", done, 0);

    mthi = 1'b1; hi_wdata = 32'hAA;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi_idle_hi", hi, 32'hAA);
    checkOutput("mthi_idle_lo", lo, mLo);
    mHi = 32'hAA;
    mtlo = 1'b1; lo_wdata = 32'h55;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo_idle_lo", lo, 32'h55);
    mLo = 32'h55;

    applyStimulus("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
    applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 0, 0);
    applyStimulus("divu_zero", OP_DIVU, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFF_FFFF, 1, 0, 0);
    applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 0, 0, 0);
    applyStimulus("mult_disturb", OP_MULT, 32'd12345, 32'hFFFF_FFFE, 0, '0, '0, 0, 1, 0);
    repeat (2) @(negedge clk);
    applyStimulus("multu_start_mt", OP_MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, 0, 1);

    for (int i = 0; i < 4; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      applyStimulus($sformatf("rand%0d", i), ro, ra, rb, 0, '0, '0, 0, 0, 0);
    end

    mthi = 1'b1; hi_wdata = 32'hAA;
    @(negedge clk);
    mthi = 1'b0;
    op = OP_MULT; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_hi", hi, 0);
    checkOutput("midreset_lo", lo, 0);
    checkOutput("midreset_done", done, 0);
    mHi = '0; mLo = '0; mDz = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("midreset_no_done", doneCount, 0);
    applyStimulus("after_reset", OP_MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
